vga_sync_receptor: RTL and testbench
====================================

Name: vga_sync_receptor

Overview:
- Receive end of the 640x480 VGA timing interface: takes sampled hsync/vsync (active-low) plus the per-pixel enable, recovers pixel coordinates and the active-video window, and reports lock to the standard 800x525 raster.
- Sits downstream of the sync generator (or an external video source) in capture/checking paths, so loopback tests and frame grabbers can tell where they are in the raster.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- TIMEOUT, 1600, pix_en samples without an hsync fall before dropping to SEARCH
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL (525) are localparams

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pix_en  in  1  one-clk pixel-rate enable (25 MHz tick); all sampling and counting happens only on clk edges with pix_en=1
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- px  out  10  recovered column, 0..H_TOTAL-1
- py  out  10  recovered line, 0..V_TOTAL-1
- vidon  out  1  locked && px<H_ACTIVE && py<V_ACTIVE
- locked  out  1  raster lock indication
- err  out  1  one-clk pulse on loss of lock
- line_len  out  11  last measured hsync period (MEAS_OUT_EN)
- frame_len  out  10  last measured vsync period in lines (MEAS_OUT_EN)

Behaviour:
- Reset (rst=0, async): px=0, py=0, vidon=0, locked=0, err=0, all counters 0, state SEARCH, previous-sample registers hs_p=1, vs_p=1 (idle-high syncs).
- Sampling: on each pix_en edge, hs_p<=hsync_in and vs_p<=vsync_in. H fall = hs_p=1 && hsync_in=0 on that edge; V fall is the same for vsync. pix_en=0 edges change nothing except err clearing.
- Coordinates: at an H fall edge, px<=H_ACTIVE+H_FP (656). Otherwise px increments, wrapping H_TOTAL-1 -> 0. On a wrap, py increments, wrapping V_TOTAL-1 -> 0. At a V fall edge, py<=V_ACTIVE+V_FP (490), overriding any increment on the same edge.
- Outputs are registered: zero latency from the sampling edge.
- Period counter pcnt (11 bit, saturating at 2047): counts pix_en samples. At an H fall, line_len<=pcnt+1 and pcnt<=0. A line is good when pcnt+1==H_TOTAL.
- Line counter lcnt: counts H falls. At a V fall, frame_len<=lcnt and lcnt<=0. A frame is good when lcnt==V_TOTAL.
- FSM states:
  - SEARCH: px/py held at 0, locked=0. First H fall -> HTRACK, with coordinates loaded as above.
  - HTRACK: a bad line clears the good-run flag. First V fall -> VCHECK, clearing lcnt and setting the frame-good flag.
  - VCHECK: any bad line clears frame-good. At a V fall: if the frame is good and frame-good=1 -> LOCKED (locked<=1 on that edge); else stay in VCHECK and re-arm.
  - LOCKED: a bad line or a bad frame causes err pulse, locked<=0 and -> HTRACK; coordinates keep following syncs.
  - Any state except SEARCH: TIMEOUT consecutive samples with no H fall -> SEARCH, with err pulse if the state was LOCKED.
- Simultaneous H and V fall on one edge: process H first (px load, line check), then V (py load, frame check, counting this line).
- vidon and locked drop on the same edge the loss is detected.

Optional Feature:
- Macro: VGA_RX_MEAS_OUT_EN.
- Defined: line_len and frame_len are registered as above, reset to 0.
- Undefined: both ports are tied to constant 0, with no measurement registers beyond those the lock checks need (pcnt, lcnt).

Test Plan:
- Drive ideal 800x525 timing from the sync generator model with pix_en every 4th clk -> locked=1 at the second V fall. At the next column-0/line-0 sample, px=0, py=0, vidon=1. At px=640, vidon=0.
- Source with 801-pixel lines -> locked never asserts over 3 frames; line_len=801.
- After lock, shorten one hsync period to 700 samples -> err high for exactly 1 clk, locked=0, state HTRACK. Relock after 2 good V falls.
- After lock, hold hsync_in high -> 1600 samples later err pulse, px=py=0, locked=0 (SEARCH).
- Assert rst=0 mid-line at px=300 -> px, py, locked, vidon go to 0 immediately (async). After release, relock takes 2 full frames.
- Freeze pix_en low for 50 clks mid-line -> px/py/pcnt hold. On resume, lock is retained and counting continues from the held value.

Source files
------------

// File: rtl/vga_sync_receptor.sv
// vga_sync_receptor: receive side of the VGA timing interface. Samples the
// active-low hsync/vsync on each pixel enable, rebuilds the pixel column and
// line, flags the visible window and tracks lock to the nominal raster.
// Optional build macro VGA_RX_MEAS_OUT_EN: when defined, the last measured
// hsync period (pixels) and vsync period (lines) are registered on line_len
// and frame_len; when undefined both ports read as constant 0.
module vga_sync_receptor #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int TIMEOUT  = 1600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [9:0]  px,
   output logic [9:0]  py,
   output logic        vidon,
   output logic        locked,
   output logic        err,
   output logic [10:0] line_len,
   output logic [9:0]  frame_len
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  PX_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0]  PY_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0]  PX_LOAD  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  PY_LOAD  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  PX_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  PY_LAST  = 10'(V_TOTAL - 1);
   localparam logic [10:0] LINE_OK  = 11'(H_TOTAL);
   localparam logic [9:0]  FRAME_OK = 10'(V_TOTAL);
   localparam logic [10:0] TMO_CNT  = 11'(TIMEOUT);

   typedef enum logic [1:0] { SEARCH, HTRACK, VCHECK, LOCKED } state_t;

   state_t      state, state_n;
   logic        hs_p, vs_p;
   logic        hfall, vfall;
   logic [10:0] pcnt, pcnt_n, pcnt_inc;
   logic [9:0]  lcnt, lcnt_n, lcnt_inc;
   logic        fgood, fgood_n;
   logic        line_good, frame_good, tmo;
   logic [9:0]  px_adv, py_adv, px_n, py_n;
   logic        locked_n, vidon_n, err_n;

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == '1) ? v : v + 11'd1;
   endfunction

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == '1) ? v : v + 10'd1;
   endfunction

   // Sync fall detection, saturating period/line counts and the checks they feed
   always_comb begin
      hfall      = hs_p & ~hsync_in;
      vfall      = vs_p & ~vsync_in;
      pcnt_inc   = sat_inc11(pcnt);
      lcnt_inc   = hfall ? sat_inc10(lcnt) : lcnt;
      line_good  = (pcnt_inc == LINE_OK);
      frame_good = (lcnt_inc == FRAME_OK);
      tmo        = (state != SEARCH) && !hfall && (pcnt_inc >= TMO_CNT);
      if (px == PX_LAST) begin
         px_adv = '0;
         py_adv = (py == PY_LAST) ? '0 : py + 10'd1;
      end else begin
         px_adv = px + 10'd1;
         py_adv = py;
      end
   end

   // Lock FSM: the H fall is resolved first, then the V fall sees the post-H state
   always_comb begin
      state_n  = state;
      fgood_n  = fgood;
      locked_n = locked;
      err_n    = 1'b0;
      pcnt_n   = hfall ? '0 : pcnt_inc;
      lcnt_n   = vfall ? '0 : lcnt_inc;

      case (state)
         SEARCH: if (hfall) state_n = HTRACK;
         HTRACK,
         VCHECK: if (hfall && !line_good) fgood_n = 1'b0;
         LOCKED: if (hfall && !line_good) begin
            state_n  = HTRACK;
            locked_n = 1'b0;
            err_n    = 1'b1;
         end
         default: state_n = SEARCH;
      endcase

      if (vfall) begin
         case (state_n)
            HTRACK: begin
               state_n = VCHECK;
               fgood_n = 1'b1;
            end
            VCHECK: begin
               if (frame_good && fgood_n) begin
                  state_n  = LOCKED;
                  locked_n = 1'b1;
               end
               fgood_n = 1'b1;
            end
            LOCKED: if (!frame_good) begin
               state_n  = HTRACK;
               locked_n = 1'b0;
               err_n    = 1'b1;
            end
            default: ;
         endcase
      end

      if (tmo) begin
         state_n  = SEARCH;
         locked_n = 1'b0;
         err_n    = (state == LOCKED);
      end

      if (state_n == SEARCH) begin
         px_n = '0;
         py_n = '0;
      end else begin
         px_n = hfall ? PX_LOAD : px_adv;
         py_n = vfall ? PY_LOAD : (hfall ? py : py_adv);
      end

      vidon_n = locked_n && (px_n < PX_ACT) && (py_n < PY_ACT);
   end

   // State, counters and registered outputs advance only on pixel samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= SEARCH;
         hs_p   <= 1'b1;
         vs_p   <= 1'b1;
         pcnt   <= '0;
         lcnt   <= '0;
         fgood  <= 1'b0;
         px     <= '0;
         py     <= '0;
         locked <= 1'b0;
         vidon  <= 1'b0;
         err    <= 1'b0;
      end else begin
         err <= 1'b0;
         if (pix_en) begin
            state  <= state_n;
            hs_p   <= hsync_in;
            vs_p   <= vsync_in;
            pcnt   <= pcnt_n;
            lcnt   <= lcnt_n;
            fgood  <= fgood_n;
            px     <= px_n;
            py     <= py_n;
            locked <= locked_n;
            vidon  <= vidon_n;
            err    <= err_n;
         end
      end
   end

`ifdef VGA_RX_MEAS_OUT_EN
   // Capture the period just closed by each sync fall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_len  <= '0;
         frame_len <= '0;
      end else if (pix_en) begin
         if (hfall) line_len  <= pcnt_inc;
         if (vfall) frame_len <= lcnt_inc;
      end
   end
`else
   assign line_len  = '0;
   assign frame_len = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receptor.sv
// tb_vga_sync_receptor: drives a scaled-down raster (25x12) into the receptor
// and checks every clock against a sample-indexed reference model, plus
// directed literal checks of lock timing, error pulses, timeout and reset.
module tb_vga_sync_receptor;

   localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
   localparam int VA = 8,  VFP = 1, VS = 1, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;   // 25
   localparam int VT = VA + VFP + VS + VBP;   // 12
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_en = 1'b0;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic [9:0]  px, py;
   logic        vidon, locked, err;
   logic [10:0] line_len;
   logic [9:0]  frame_len;

   always #5 clk = ~clk;

   vga_sync_receptor #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .px(px), .py(py), .vidon(vidon), .locked(locked), .err(err),
      .line_len(line_len), .frame_len(frame_len)
   );

   int checks = 0;
   int errors = 0;
   int err_hi = 0;

   // reference model: positions are derived from the sample distance to the
   // most recent sync anchor rather than from stepped counters
   int n, last_h, hcount, anc_px, anc_py, anc_n;
   bit acq, armed, run_ok, m_hs, m_vs;
   int e_px, e_py, e_ll, e_fl;
   bit e_vid, e_lock, e_err;

   task automatic model_reset();
      n = 0; last_h = 0; hcount = 0; anc_px = 0; anc_py = 0; anc_n = 0;
      acq = 0; armed = 0; run_ok = 0; m_hs = 1; m_vs = 1;
      e_px = 0; e_py = 0; e_ll = 0; e_fl = 0; e_vid = 0; e_lock = 0; e_err = 0;
   endtask

   task automatic model_step(input bit pe, input bit hs, input bit vs);
      bit hf, vf, was_locked, was_acq;
      int span, pos;
      e_err = 0;
      if (!pe) return;
      n++;
      hf = m_hs && !hs;
      vf = m_vs && !vs;
      m_hs = hs;
      m_vs = vs;
      span = n - last_h;
      was_locked = e_lock;
      was_acq = acq;
      if (hf) begin
         e_ll = (span > 2047) ? 2047 : span;
         last_h = n;
         if (hcount < 1023) hcount++;
         if (!acq) begin
            acq = 1; armed = 0;
         end else if (span != HT) begin
            run_ok = 0;
            if (e_lock) begin e_lock = 0; e_err = 1; armed = 0; end
         end
         anc_py = e_py; anc_px = HA + HFP; anc_n = n;
      end
      if (vf) begin
         e_fl = hcount;
         if (acq) begin
            if (!armed) begin
               armed = 1; run_ok = 1;
            end else if (e_lock) begin
               if (hcount != VT) begin e_lock = 0; e_err = 1; armed = 0; end
            end else begin
               if (hcount == VT && run_ok) e_lock = 1;
               run_ok = 1;
            end
         end
         hcount = 0;
         if (!hf) begin anc_px = (anc_px + n - anc_n) % HT; anc_n = n; end
         anc_py = VA + VFP;
      end
      if (was_acq && !hf && span >= TMO) begin
         e_err = was_locked; e_lock = 0; acq = 0; armed = 0;
      end
      if (!acq) begin
         e_px = 0; e_py = 0;
      end else begin
         pos  = anc_px + (n - anc_n);
         e_px = pos % HT;
         e_py = (anc_py + pos / HT) % VT;
      end
      e_vid = e_lock && (e_px < HA) && (e_py < VA);
   endtask

   // per-clock comparison against the model, away from the active edge
   initial begin
      int exp_ll, exp_fl;
      forever begin
         @(negedge clk);
         if (err) err_hi++;
`ifdef VGA_RX_MEAS_OUT_EN
         exp_ll = e_ll; exp_fl = e_fl;
`else
         exp_ll = 0; exp_fl = 0;
`endif
         checks++;
         if (int'(px) != e_px || int'(py) != e_py || vidon !== e_vid || locked !== e_lock ||
             err !== e_err || int'(line_len) != exp_ll || int'(frame_len) != exp_fl) begin
            errors++;
            $display("FAIL model t=%0t got px=%0d py=%0d vid=%b lk=%b err=%b ll=%0d fl=%0d exp px=%0d py=%0d vid=%b lk=%b err=%b ll=%0d fl=%0d",
                     $time, px, py, vidon, locked, err, line_len, frame_len,
                     e_px, e_py, e_vid, e_lock, e_err, exp_ll, exp_fl);
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic clk_step(input bit pe, input bit hs, input bit vs);
      @(negedge clk);
      pix_en = pe; hsync_in = hs; vsync_in = vs;
      @(posedge clk);
      model_step(pe, hs, vs);
      #1;
   endtask

   // raster generator: one sample every 4th clock
   int gx = 0, gy = 0, hlen = HT;
   bit hold_h = 0;

   task automatic gen_sample();
      bit hs, vs;
      hs = hold_h || !(gx >= HA + HFP && gx < HA + HFP + HS);
      vs = !(gy >= VA + VFP && gy < VA + VFP + VS);
      repeat (3) clk_step(0, hsync_in, vsync_in);
      clk_step(1, hs, vs);
      gx++;
      if (gx >= hlen) begin gx = 0; gy = (gy + 1) % VT; end
   endtask

   task automatic run_to(input int x, input int y);
      int k = 0;
      while (!(gx == x && gy == y) && k < 2000) begin gen_sample(); k++; end
      check("run_to_reached", int'(gx == x && gy == y), 1);
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      rst = 1'b0;
      model_reset();
      repeat (2) clk_step(0, 1'b1, 1'b1);
      @(negedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lock_idx, k, vcount, sidx;
      bit seen;
      model_reset();
      repeat (4) clk_step(0, 1'b1, 1'b1);
      check("rst_px", int'(px), 0);
      check("rst_py", int'(py), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_vidon", int'(vidon), 0);
      check("rst_err", int'(err), 0);
      @(negedge clk); #1;
      rst = 1'b1;

      // ideal raster: lock on the second V fall (sample 525)
      lock_idx = -1;
      for (sidx = 0; sidx < 700 && lock_idx < 0; sidx++) begin
         gen_sample();
         if (locked) lock_idx = sidx;
      end
      check("lock_sample", lock_idx, 525);
      check("lock_px", int'(px), 0);
      check("lock_py", int'(py), VA + VFP);
      run_to(0, 0); gen_sample();
      check("origin_px", int'(px), 0);
      check("origin_py", int'(py), 0);
      check("origin_vidon", int'(vidon), 1);
      run_to(HA, 0); gen_sample();
      check("edge_px", int'(px), HA);
      check("edge_vidon", int'(vidon), 0);

      // pix_en frozen mid-line: everything holds
      run_to(5, 2); gen_sample();
      repeat (50) clk_step(0, hsync_in, vsync_in);
      check("freeze_px", int'(px), 5);
      check("freeze_py", int'(py), 2);
      check("freeze_locked", int'(locked), 1);
      gen_sample();
      check("resume_px", int'(px), 6);
      run_to(0, 3);
      check("resume_locked", int'(locked), 1);

      // one short line: single-clock err, relock after two V falls
      err_hi = 0;
      hlen = 20;
      repeat (20) gen_sample();
      hlen = HT;
      run_to(0, 5);
      check("short_err_clks", err_hi, 1);
      check("short_locked", int'(locked), 0);
      run_to(1, 9);
      check("relock_first_vfall", int'(locked), 0);
      gen_sample();
      run_to(0, 9);
      check("relock_before", int'(locked), 0);
      gen_sample();
      check("relock_second_vfall", int'(locked), 1);

      // hsync stuck high after lock: timeout 58 held samples later
      run_to(0, 0);
      hold_h = 1;
      k = 0; seen = 0;
      while (!seen && k < 200) begin
         gen_sample(); k++;
         if (err) seen = 1;
      end
      hold_h = 0;
      check("timeout_samples", k, TMO - (HT - (HA + HFP) - 1));
      check("timeout_px", int'(px), 0);
      check("timeout_py", int'(py), 0);
      check("timeout_locked", int'(locked), 0);

      // async reset mid-line while locked
      k = 0;
      while (!locked && k < 900) begin gen_sample(); k++; end
      check("pre_reset_locked", int'(locked), 1);
      run_to(10, 3); gen_sample();
      check("pre_reset_px", int'(px), 10);
      @(negedge clk); #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_px", int'(px), 0);
      check("async_py", int'(py), 0);
      check("async_locked", int'(locked), 0);
      check("async_vidon", int'(vidon), 0);
      repeat (2) clk_step(0, 1'b1, 1'b1);
      @(negedge clk); #1;
      rst = 1'b1;
      k = 0; vcount = 0;
      while (!locked && k < 900) begin
         if (gx == 0 && gy == VA + VFP) vcount++;
         gen_sample(); k++;
      end
      check("reset_relock_vfalls", vcount, 2);

      // 26-sample lines never lock
      do_reset();
      gx = 0; gy = 0; hlen = HT + 1;
      seen = 0;
      repeat (3 * VT * (HT + 1)) begin
         gen_sample();
         if (locked) seen = 1;
      end
      hlen = HT;
      check("long_line_never_locked", int'(seen), 0);
`ifdef VGA_RX_MEAS_OUT_EN
      check("long_line_len", int'(line_len), HT + 1);
      check("long_frame_len", int'(frame_len), VT);
`else
      check("long_line_len", int'(line_len), 0);
      check("long_frame_len", int'(frame_len), 0);
`endif

      repeat (4) clk_step(0, hsync_in, vsync_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
